demux_1to8_stream: RTL and testbench
====================================

# demux_1to8_stream

Registered 1-to-8 stream demultiplexer: the distribution-side counterpart of the team's 8-to-1 selector. It accepts a packetised input stream with valid/ready flow control and routes each packet to one of eight output channels. The route comes from a 3-bit select, latched on the first beat of each packet. Each output channel has a one-entry holding register, so every output is registered and back-pressure is handled per channel. It sits between a shared producer (bus or arbiter output) and eight independent consumers.

## Interface
- DATA_W, 8, width of a data beat
- CNT_W, 16, width of per-channel beat counters (used only with DEMUX_BEAT_CNT_EN)
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- in_data  input  DATA_W  input beat
- in_sel  input  3  destination channel, sampled on the first beat of a packet
- in_last  input  1  marks the final beat of a packet
- in_valid  input  1  input beat present
- in_ready  output  1  input beat accepted this cycle when in_valid is also high
- out_data  output  8*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
- out_last  output  8  per-channel last flag
- out_valid  output  8  per-channel holding register full
- out_ready  input  8  per-channel consumer accept
- beat_cnt  output  8*CNT_W  per-channel accepted-beat counters; channel k occupies bits [k*CNT_W +: CNT_W]

## Operation
- Handshake: a beat transfers on any edge where valid and ready are both high, on the input side and on each output side independently.
- FSM states:
  - IDLE: no packet open.
  - ROUTE: packet open; the route is held in cur_sel.
- IDLE:
  - in_ready = (slot[in_sel] empty) OR (out_valid[in_sel] AND out_ready[in_sel]).
  - On an input transfer: cur_sel <= in_sel; the beat is written to slot[in_sel].
  - If in_last=1, stay in IDLE (single-beat packet). Otherwise go to ROUTE.
- ROUTE:
  - in_sel is ignored. The same in_ready equation applies, using cur_sel.
  - On a transfer with in_last=1, return to IDLE.
- Slot write: out_data, out_last and out_valid of the target channel are loaded on the accepting edge.
- Slot drain: out_valid[k] clears on an output transfer unless the same edge refills the slot (simultaneous drain and fill leaves out_valid[k]=1 with the new data).
- Only the target channel is written. Other channels drain independently and concurrently.
- A full, stalled non-target channel never blocks traffic to other channels.
- in_valid low in ROUTE is legal (gaps inside a packet). The FSM holds state.
- in_ready depends combinationally on out_ready of the target channel. out_valid, out_data and out_last are purely registered.

## Timing
- Reset (rst_n low at an edge):
  - FSM goes to IDLE, cur_sel=0.
  - out_valid=0, out_last=0, out_data=0, beat_cnt=0.
  - The input side is not ready while rst_n is low.
- Reset mid-packet: the packet is discarded. The first accepted beat after reset is treated as a packet start.
- Latency: input transfer at edge N → out_valid[k]=1 after edge N. Minimum one cycle, no maximum.
- Throughput: one beat per cycle to a single channel whose consumer holds out_ready=1.
- Back-pressure: with slot k full and out_ready[k]=0, in_ready=0 while k is the target. in_data and in_valid must then be held by the producer.

## Configuration
- Macro: DEMUX_BEAT_CNT_EN.
- Defined:
  - Each channel has a CNT_W-bit counter that increments on every output transfer of that channel.
  - Counters wrap from all-ones to 0 and are cleared by reset.
- Undefined:
  - No counter logic is built.
  - beat_cnt is tied to 0 (the port remains, so the interface is identical).

## Structure
- Shared package demux_pkg holds:
  - N_CH=8 and SEL_W=3 constants.
  - FSM state typedef (IDLE, ROUTE).
  - Default DATA_W and CNT_W localparams.
- Sub-module demux_out_slot: one-entry holding register with wr_en, data/last in, valid/ready out, and an optional counter. Instantiated 8 times by a generate loop.
- The top level contains the FSM, cur_sel, the in_ready mux and the write decode.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with in_valid=1 → out_valid=8'h00, in_ready=0, beat_cnt all 0.
- Single-beat routing: send in_data=8'hA5, in_sel=5, in_last=1, all out_ready=0 → next cycle out_valid=8'h20 and channel 5 data=8'hA5. A second beat to channel 5 stalls (in_ready=0).
- Select latching: 4-beat packet 8'h10..8'h13 with in_sel=2 on beat 0, in_sel toggled to 6 on beats 1-3, out_ready=8'hFF → all 4 beats appear on channel 2 in order, out_last only on the 4th, nothing on channel 6.
- Independent back-pressure: fill channel 0 with out_ready[0]=0, then send a packet to channel 3 → channel 3 receives at full rate while channel 0 holds its data.
- Simultaneous drain/fill: channel 1 full with out_ready[1]=1 and a new beat 8'h77 arriving the same cycle → in_ready=1, out_valid[1] stays 1, data becomes 8'h77, no beat lost.
- Mid-packet reset, plus counters with DEMUX_BEAT_CNT_EN and CNT_W=4:
  - Reset after beat 2 of a packet to channel 4, then send a 1-beat packet with in_sel=7 → the beat goes to channel 7.
  - 17 beats to channel 0 → beat_cnt[0]=1 (wrap).

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and FSM state type for the 1-to-8 stream demultiplexer.
// The optional per-channel beat counters are enabled by the DEMUX_BEAT_CNT_EN macro.
package demux_pkg;

  localparam int unsigned N_CH       = 8;
  localparam int unsigned SEL_W      = 3;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ROUTE = 1'b1
  } state_e;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output holding register for a single demux channel.
// The optional accepted-beat counter is built only when DEMUX_BEAT_CNT_EN is defined.
module demux_out_slot #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              free_c,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  beat_cnt
);

  // Slot can take a new beat when empty or when it drains on this edge.
  assign free_c = !out_valid || out_ready;

  // A write wins over a drain, so a simultaneous drain and fill stays valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (wr_en) begin
      out_valid <= 1'b1;
      out_data  <= wr_data;
      out_last  <= wr_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DEMUX_BEAT_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (out_valid && out_ready) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign beat_cnt = cnt_q;
`else
  assign beat_cnt = '0;
`endif

endmodule

// File: rtl/demux_1to8_stream.sv
// Registered 1-to-8 packet stream demultiplexer with per-channel holding slots.
// Per-channel beat counters are built when DEMUX_BEAT_CNT_EN is defined.
module demux_1to8_stream
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_last,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic [N_CH-1:0]        out_last,
  output logic [N_CH-1:0]        out_valid,
  input  logic [N_CH-1:0]        out_ready,
  output logic [N_CH*CNT_W-1:0]  beat_cnt
);

  state_e           state_q;
  state_e           state_d;
  logic [SEL_W-1:0] cur_sel_q;
  logic [SEL_W-1:0] cur_sel_d;
  logic [SEL_W-1:0] tgt_sel_c;
  logic             xfer_c;
  logic [N_CH-1:0]  wr_en_c;
  logic [N_CH-1:0]  slot_free_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cur_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
    end
  end

  // Route select, input handshake, write decode and packet framing.
  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    wr_en_c   = '0;
    tgt_sel_c = (state_q == IDLE) ? in_sel : cur_sel_q;
    in_ready  = rst_n && slot_free_c[tgt_sel_c];
    xfer_c    = in_valid && in_ready;

    if (xfer_c) begin
      wr_en_c[tgt_sel_c] = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (xfer_c) begin
          cur_sel_d = in_sel;
          if (!in_last) begin
            state_d = ROUTE;
          end
        end
      end
      ROUTE: begin
        if (xfer_c && in_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    demux_out_slot #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en_c[k]),
      .wr_data   (in_data),
      .wr_last   (in_last),
      .free_c    (slot_free_c[k]),
      .out_data  (out_data[k*DATA_W +: DATA_W]),
      .out_last  (out_last[k]),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .beat_cnt  (beat_cnt[k*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_demux_1to8_stream.sv
// Self-checking bench for demux_1to8_stream: directed steps plus randomized traffic
// against a per-channel slot model; counter checks follow DEMUX_BEAT_CNT_EN.
module tb_demux_1to8_stream;

  localparam int unsigned DATA_W = 8;
`ifdef DEMUX_BEAT_CNT_EN
  localparam int unsigned CNT_W = 4;
`else
  localparam int unsigned CNT_W = 16;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic [DATA_W-1:0]   in_data;
  logic [2:0]          in_sel;
  logic                in_last;
  logic                in_valid;
  logic                in_ready;
  logic [8*DATA_W-1:0] out_data;
  logic [7:0]          out_last;
  logic [7:0]          out_valid;
  logic [7:0]          out_ready;
  logic [8*CNT_W-1:0]  beat_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one holding slot per channel plus the open-packet route.
  bit       m_valid [8];
  bit [7:0] m_data  [8];
  bit       m_last  [8];
  int       m_cnt   [8];
  bit       m_open;
  int       m_route;

  demux_1to8_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, check in_ready mid-cycle, advance the model, check outputs after the edge.
  task automatic cycle(input logic r, input logic v, input logic [2:0] s,
                       input logic [7:0] d, input logic l, input logic [7:0] o);
    int tgt;
    bit exp_rdy;
    rst_n = r; in_valid = v; in_sel = s; in_data = d; in_last = l; out_ready = o;
    #2;
    tgt = m_open ? m_route : int'(s);
    exp_rdy = r && (!m_valid[tgt] || o[tgt]);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (!r) begin
      for (int k = 0; k < 8; k++) begin
        m_valid[k] = 0; m_data[k] = 0; m_last[k] = 0; m_cnt[k] = 0;
      end
      m_open = 0; m_route = 0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (m_valid[k] && o[k]) begin
          m_valid[k] = 0;
          m_cnt[k] = (m_cnt[k] + 1) % (1 << CNT_W);
        end
      end
      if (v && exp_rdy) begin
        m_valid[tgt] = 1; m_data[tgt] = d; m_last[tgt] = l;
        m_open = !l; m_route = tgt;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("valid[%0d]", k), 32'(out_valid[k]), 32'(m_valid[k]));
      if (m_valid[k] || !r) begin
        chk($sformatf("data[%0d]", k), 32'(out_data[k*DATA_W +: DATA_W]), 32'(m_data[k]));
        chk($sformatf("last[%0d]", k), 32'(out_last[k]), 32'(m_last[k]));
      end
`ifdef DEMUX_BEAT_CNT_EN
      chk($sformatf("cnt[%0d]", k), 32'(beat_cnt[k*CNT_W +: CNT_W]), 32'(m_cnt[k]));
`else
      chk($sformatf("cnt[%0d]", k), 32'(beat_cnt[k*CNT_W +: CNT_W]), 32'd0);
`endif
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      m_valid[k] = 0; m_data[k] = 0; m_last[k] = 0; m_cnt[k] = 0;
    end
    m_open = 0; m_route = 0;

    // Reset with in_valid high
    cycle(1'b0, 1'b1, 3'd1, 8'h11, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 3'd1, 8'h11, 1'b1, 8'h00);
    chk("rst_valid", 32'(out_valid), 32'h00);
    chk("rst_cnt", beat_cnt[31:0], 32'd0);

    // Single-beat packet to channel 5, then a stalled second beat
    cycle(1'b1, 1'b1, 3'd5, 8'hA5, 1'b1, 8'h00);
    chk("single_valid", 32'(out_valid), 32'h20);
    chk("single_data", 32'(out_data[5*DATA_W +: DATA_W]), 32'hA5);
    cycle(1'b1, 1'b1, 3'd5, 8'h5A, 1'b1, 8'h00);
    chk("stall_data", 32'(out_data[5*DATA_W +: DATA_W]), 32'hA5);

    // Select latched on first beat only
    for (int b = 0; b < 4; b++) begin
      cycle(1'b1, 1'b1, (b == 0) ? 3'd2 : 3'd6, 8'(8'h10 + b), (b == 3), 8'hFF);
      chk("latch_data", 32'(out_data[2*DATA_W +: DATA_W]), 32'(8'h10 + b));
      chk("latch_last", 32'(out_last[2]), 32'(b == 3));
      chk("latch_ch6", 32'(out_valid[6]), 32'd0);
    end
    cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 8'hFF);

    // Channel 0 stalled full while channel 3 streams at full rate
    cycle(1'b1, 1'b1, 3'd0, 8'hC0, 1'b1, 8'h00);
    for (int b = 0; b < 4; b++) begin
      cycle(1'b1, 1'b1, 3'd3, 8'(8'h30 + b), (b == 3), 8'h08);
      chk("indep_ch3", 32'(out_data[3*DATA_W +: DATA_W]), 32'(8'h30 + b));
      chk("indep_ch0", 32'({out_valid[0], out_data[7:0]}), 32'h1C0);
    end

    // Simultaneous drain and fill on channel 1
    cycle(1'b1, 1'b1, 3'd1, 8'h66, 1'b1, 8'h00);
    cycle(1'b1, 1'b1, 3'd1, 8'h77, 1'b1, 8'h02);
    chk("df_valid", 32'(out_valid[1]), 32'd1);
    chk("df_data", 32'(out_data[1*DATA_W +: DATA_W]), 32'h77);
    cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 8'hFF);

    // Reset inside a packet to channel 4; next beat is a fresh packet start
    cycle(1'b1, 1'b1, 3'd4, 8'h40, 1'b0, 8'hFF);
    cycle(1'b1, 1'b1, 3'd4, 8'h41, 1'b0, 8'hFF);
    cycle(1'b0, 1'b0, 3'd4, 8'h00, 1'b0, 8'hFF);
    cycle(1'b1, 1'b1, 3'd7, 8'h7E, 1'b1, 8'h00);
    chk("midrst_valid", 32'(out_valid), 32'h80);
    chk("midrst_data", 32'(out_data[7*DATA_W +: DATA_W]), 32'h7E);

    // 17 beats through channel 0
    for (int b = 0; b < 17; b++) cycle(1'b1, 1'b1, 3'd0, 8'(b), (b == 16), 8'hFF);
    cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 8'hFF);
`ifdef DEMUX_BEAT_CNT_EN
    chk("cnt_wrap", 32'(beat_cnt[0 +: CNT_W]), 32'd1);
`endif

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0,
            3'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 3) == 0,
            8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
